result_ascii_tx: RTL and testbench
==================================

# result_ascii_tx

Downstream output stage for the day solvers: captures the 32-bit `output_data` result once `output_data_valid` rises, converts it to unsigned decimal ASCII and streams the characters (most-significant digit first, then `"\n"`) over a byte valid/ready handshake toward the UART/console sink. It fires exactly once per reset, so the solver's level-held `output_data_valid` produces a single line.

## Interface
- `WIDTH`, default 32: result width in bits; the conversion takes WIDTH cycles.
- `NDIGITS`, default 10: BCD digits held; must cover 2^WIDTH-1 (10 for 32).
- `EMIT_NL`, default 1: when 1, append `"\n"` (0x0A) after the last digit.
- `clk  in  1`: sole clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `result_data  in  WIDTH`: solver result; sampled only in the capture cycle.
- `result_valid  in  1`: solver result-valid; level or pulse accepted.
- `tx_byte  out  8`: ASCII character.
- `tx_valid  out  1`: `tx_byte` is valid.
- `tx_ready  in  1`: sink accepts `tx_byte` this cycle.
- `busy  out  1`: high in any state other than IDLE and DONE.
- `done  out  1`: level; high once the final byte has transferred; held until reset.

## Operation
- States: IDLE, CONVERT, SKIP, EMIT, NEWLINE, DONE.
- IDLE: while `result_valid` is high, latch `result_data`, clear the BCD register, and move to CONVERT.
- CONVERT: double-dabble. Each cycle, add 3 to every BCD nibble that is at least 5, then shift {bcd, bin} left by 1. After exactly WIDTH cycles, set the digit index to NDIGITS-1 and move to SKIP.
- SKIP: suppresses leading zeros. While the digit at the index is 0 and the index is above 0, decrement the index by one per cycle. Otherwise move to EMIT. A value of 0 therefore emits a single `"0"`.
- EMIT: `tx_byte` = 0x30 + digit[index], with `tx_valid`=1.
  - On transfer (`tx_valid && tx_ready`) with index>0: decrement the index.
  - On transfer with index==0: go to NEWLINE if EMIT_NL, else go to DONE.
- NEWLINE: `tx_byte`=0x0A, `tx_valid`=1; on transfer, go to DONE.
- DONE: `tx_valid`=0 and `done`=1. `result_valid` is ignored, so the solver holding it high causes no re-emission. Only `rst` leaves DONE.
- Handshake rules:
  - Once `tx_valid` is asserted, `tx_valid` and `tx_byte` stay stable until transfer.
  - `tx_valid` never depends combinationally on `tx_ready`.
  - No byte is dropped or duplicated.
- Arithmetic:
  - BCD nibble corrections are 4-bit and never overflow, because NDIGITS is sized for WIDTH.
  - The digit index is $clog2(NDIGITS) bits and never wraps below 0.

## Timing
- Reset values: `tx_byte`=0, `tx_valid`=0, `busy`=0, `done`=0; state IDLE; internal registers cleared.
- Reset mid-operation:
  - `rst` high in any state: outputs take their reset values in the following cycle.
  - A byte presented but not yet transferred is abandoned.
- Capture: with `result_valid` high in IDLE at cycle t, CONVERT occupies cycles t+1 .. t+WIDTH.
- SKIP lasts 1 + (number of leading zero digits) cycles, capped at NDIGITS cycles.
- For a value with d digits, the first `tx_valid` is at cycle t + WIDTH + 1 + (NDIGITS - d) + 1.
- Throughput: one byte per cycle when `tx_ready` is held high.
- `done` rises the cycle after the final transfer.
- `busy` is high from t+1 until the cycle `done` rises.

## Structure
- Package `aoc_out_pkg`:
  - state enum `tx_state_t`;
  - constants `ASCII_ZERO`=8'h30 and `ASCII_NL`=8'h0A.
- Sub-module `bin2bcd_seq` (WIDTH, NDIGITS):
  - inputs `start`, `bin`;
  - outputs `bcd[4*NDIGITS-1:0]`, `bcd_valid`;
  - provides the iterative double-dabble.
- The top module holds the capture, the SKIP/EMIT/NEWLINE sequencer and the handshake register.

## Test plan
- 41, `tx_ready`=1 → bytes 0x34, 0x31, 0x0A on consecutive cycles; first `tx_valid` at t+32+1+8+1; then `done`=1.
- 0 → bytes 0x30, 0x0A only.
- 32'hFFFFFFFF → "4294967295\n" (11 bytes, no SKIP cycles beyond 1).
- 5208 with random `tx_ready` (~50% duty) → same bytes in order; `tx_byte` and `tx_valid` stable across every stall cycle; no duplicates.
- `result_valid` held high for 200 cycles after the value 7 → exactly one "7\n"; `done` stays 1.
- `rst` pulsed during EMIT of 12345 after 2 bytes have transferred → `tx_valid`=0 next cycle; then 99 → "99\n" cleanly.

Source files
------------

// File: rtl/aoc_out_pkg.sv
// Shared types and constants for the solver result output stage.
package aoc_out_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SKIP,
        ST_EMIT,
        ST_NEWLINE,
        ST_DONE
    } tx_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    // ASCII character for one BCD digit
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: WIDTH add-3/shift steps turn bin into NDIGITS BCD digits.
// The first step is folded into the start cycle (with a cleared BCD register it is a
// plain shift), so bcd_valid is already high in the WIDTH-th cycle after start.
module bin2bcd_seq #(
    parameter int WIDTH   = 32,
    parameter int NDIGITS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       bin,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic                   bcd_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]     bin_reg;
    logic [4*NDIGITS-1:0] bcd_reg;
    logic [4*NDIGITS-1:0] bcd_adj;
    logic [CW-1:0]        cnt_reg;
    logic                 running_reg;
    logic                 valid_reg;

    // Per-nibble add-3 correction ahead of each shift
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Load on start, then one correct-and-shift step per cycle until WIDTH steps are done
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg     <= '0;
            bcd_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else if (start) begin
            bin_reg     <= bin << 1;
            bcd_reg     <= {{(4*NDIGITS-1){1'b0}}, bin[WIDTH-1]};
            cnt_reg     <= CW'(WIDTH - 1);
            running_reg <= (WIDTH > 1);
            valid_reg   <= (WIDTH == 1);
        end else if (running_reg) begin
            {bcd_reg, bin_reg} <= {bcd_adj[4*NDIGITS-2:0], bin_reg, 1'b0};
            cnt_reg            <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
                running_reg <= 1'b0;
                valid_reg   <= 1'b1;
            end
        end
    end

    assign bcd       = bcd_reg;
    assign bcd_valid = valid_reg;

endmodule

// File: rtl/result_ascii_tx.sv
// Captures one solver result, converts it to decimal ASCII and streams it MSD first
// (optionally followed by a newline) over a valid/ready byte interface, once per reset.
module result_ascii_tx
    import aoc_out_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NDIGITS = 10,
    parameter int EMIT_NL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result_data,
    input  logic             result_valid,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    tx_state_t            state_reg;
    logic [IW-1:0]        idx_reg;
    logic [7:0]           tx_byte_reg;
    logic                 tx_valid_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 start;
    logic [4*NDIGITS-1:0] bcd;
    logic                 bcd_valid;
    logic [3:0]           cur_digit;
    logic [3:0]           prev_digit;

    // Capture happens in the single IDLE cycle that sees result_valid
    assign start = (state_reg == ST_IDLE) && result_valid;

    bin2bcd_seq #(
        .WIDTH   (WIDTH),
        .NDIGITS (NDIGITS)
    ) u_bin2bcd (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (result_data),
        .bcd       (bcd),
        .bcd_valid (bcd_valid)
    );

    // Digit at the current index and at the next lower index (for back-to-back bytes)
    always_comb begin
        cur_digit  = 4'd0;
        prev_digit = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_reg == IW'(i))     cur_digit  = bcd[i*4 +: 4];
            if (idx_reg == IW'(i + 1)) prev_digit = bcd[i*4 +: 4];
        end
    end

    // Sequencer: capture, wait for conversion, skip leading zeros, emit digits and newline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            tx_byte_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (result_valid) begin
                        state_reg <= ST_CONVERT;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (bcd_valid) begin
                        state_reg <= ST_SKIP;
                        idx_reg   <= IW'(NDIGITS - 1);
                    end
                end
                ST_SKIP: begin
                    if (cur_digit == 4'd0 && idx_reg != '0) begin
                        idx_reg <= idx_reg - 1'b1;
                    end else begin
                        state_reg    <= ST_EMIT;
                        tx_valid_reg <= 1'b1;
                        tx_byte_reg  <= digit_char(cur_digit);
                    end
                end
                ST_EMIT: begin
                    if (tx_ready) begin
                        if (idx_reg != '0) begin
                            idx_reg     <= idx_reg - 1'b1;
                            tx_byte_reg <= digit_char(prev_digit);
                        end else if (EMIT_NL != 0) begin
                            state_reg   <= ST_NEWLINE;
                            tx_byte_reg <= ASCII_NL;
                        end else begin
                            state_reg    <= ST_DONE;
                            tx_valid_reg <= 1'b0;
                            tx_byte_reg  <= 8'h00;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                ST_NEWLINE: begin
                    if (tx_ready) begin
                        state_reg    <= ST_DONE;
                        tx_valid_reg <= 1'b0;
                        tx_byte_reg  <= 8'h00;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Terminal until reset; result_valid is deliberately ignored here
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_byte  = tx_byte_reg;
    assign tx_valid = tx_valid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Bench for result_ascii_tx: table of values with expected text, random values and
// random sink back-pressure against a decimal-string model, plus a mid-emit reset.
module tb_result_ascii_tx;

    localparam int WIDTH   = 32;
    localparam int NDIGITS = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] result_data = '0;
    logic             result_valid = 1'b0;
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] value;
        bit          rnd;
        int          hold;
        string       exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    result_ascii_tx #(
        .WIDTH   (WIDTH),
        .NDIGITS (NDIGITS),
        .EMIT_NL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_data  (result_data),
        .result_valid (result_valid),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Decimal text of v followed by a newline
    function automatic string model(input logic [31:0] v);
        string s;
        longint unsigned x;
        x = v;
        s = "";
        if (x == 0) s = "0";
        while (x > 0) begin
            s = $sformatf("%c%s", 8'h30 + 8'(x % 10), s);
            x = x / 10;
        end
        return {s, "\n"};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        result_valid = 1'b0;
        tx_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx_byte", 32'(tx_byte), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
    endtask

    // One capture/emit transaction; inputs change on negedges, outputs sampled there too
    task automatic run_value(input logic [31:0] v, input bit rnd, input int hold,
                             input string exp, input bit do_reset);
        int   cyc, p, first, extra, post, ndig;
        bit   prev_valid, prev_ready, ready;
        logic [7:0] prev_byte;
        string got;
        if (do_reset) apply_reset();
        @(negedge clk);
        result_data  = v;
        result_valid = 1'b1;
        tx_ready     = 1'b0;
        @(negedge clk);
        cyc = 1;
        check("busy_after_capture", 32'(busy), 32'h1);
        if (hold == 0) begin
            result_valid = 1'b0;
            result_data  = $urandom;
        end
        p = 0; first = -1; prev_valid = 0; prev_ready = 0; prev_byte = 8'h00; got = "";
        while (p < exp.len() && cyc < 3000) begin
            if (hold > 0 && cyc >= hold) result_valid = 1'b0;
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(tx_valid), 32'h1);
                check("stall_byte", 32'(tx_byte), 32'(prev_byte));
            end
            if (tx_valid && first < 0) first = cyc;
            ready    = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            tx_ready = ready;
            if (tx_valid && ready) begin
                check($sformatf("byte%0d", p), 32'(tx_byte), 32'(exp[p]));
                got = $sformatf("%s%c", got, tx_byte);
                p++;
            end
            prev_valid = tx_valid;
            prev_ready = ready;
            prev_byte  = tx_byte;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        if (p < exp.len()) begin
            total++; bad++;
            $display("FAIL timeout: got %0d bytes expected %0d", p, exp.len());
        end
        ndig = exp.len() - 1;
        check("first_valid_cycle", 32'(first), 32'(WIDTH + 1 + (NDIGITS - ndig) + 1));
        check("done_rise", 32'(done), 32'h1);
        check("busy_clear", 32'(busy), 32'h0);
        extra = 0;
        post  = ((hold > cyc) ? (hold - cyc) : 0) + 10;
        for (int k = 0; k < post; k++) begin
            if (hold > 0 && cyc >= hold) result_valid = 1'b0;
            tx_ready = bit'($urandom_range(0, 1));
            if (tx_valid) extra++;
            @(negedge clk);
            cyc++;
        end
        result_valid = 1'b0;
        tx_ready     = 1'b0;
        check("no_extra_bytes", 32'(extra), 32'h0);
        check("done_held", 32'(done), 32'h1);
        $display("txn value=%0d rnd_ready=%0d hold=%0d first_valid=%0d bytes=%0d text=%s",
                 v, rnd, hold, first, p, got.substr(0, (got.len() > 0) ? got.len() - 2 : 0));
    endtask

    initial begin
        logic [31:0] rv;
        int n;
        vec_t vv;

        vecs.push_back('{32'd41,         1'b0, 0,   "41\n"});
        vecs.push_back('{32'd0,          1'b0, 0,   "0\n"});
        vecs.push_back('{32'hFFFFFFFF,   1'b0, 0,   "4294967295\n"});
        vecs.push_back('{32'd5208,       1'b1, 0,   "5208\n"});
        vecs.push_back('{32'd7,          1'b0, 200, "7\n"});
        vecs.push_back('{32'd1000000000, 1'b1, 0,   "1000000000\n"});
        vecs.push_back('{32'd9,          1'b1, 0,   "9\n"});
        for (int i = 0; i < 8; i++) begin
            rv = $urandom >> $urandom_range(0, 31);
            vecs.push_back('{rv, bit'(i % 2), 0, model(rv)});
        end

        foreach (vecs[i]) begin
            vv = vecs[i];
            run_value(vv.value, vv.rnd, vv.hold, vv.exp, 1'b1);
        end

        // Reset while the third digit of 12345 is being presented
        apply_reset();
        @(negedge clk);
        result_data  = 32'd12345;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        tx_ready     = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 2; c++) begin
            if (tx_valid) n++;
            @(negedge clk);
        end
        check("mid_bytes_sent", 32'(n), 32'd2);
        check("mid_third_valid", 32'(tx_valid), 32'h1);
        check("mid_third_byte", 32'(tx_byte), 32'h33);
        tx_ready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        run_value(32'd99, 1'b0, 0, "99\n", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
